// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared format codes, opcodes and immediate limits
package rv_pkg;

    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_S = 2'b10,
        FMT_B = 2'b11
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field input and encoded-word output handshakes
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0]        fmt_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] addr_o;
    logic              err_o;
    logic [7:0]        err_cnt_o;

    modport slave (
        input  in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, addr_o, err_o, err_cnt_o
    );

    modport master (
        output in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, addr_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - scatters fields and immediate into an R/I/S/B word and flags range legality
module imm_pack
    import rv_pkg::*;
(
    input  logic [1:0]         fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic signed [31:0] imm,
    output logic [31:0]        inst,
    output logic               legal
);

    always_comb begin
        inst  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
        case (fmt)
            FMT_R: begin
                inst  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                inst  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = (imm >= IMM12_MIN) && (imm <= IMM12_MAX);
            end
            FMT_S: begin
                inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = (imm >= IMM12_MIN) && (imm <= IMM12_MAX);
            end
            FMT_B: begin
                // Branch offsets are halfword multiples, so bit 0 has no slot and must be clear
                inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = (imm >= IMM13_MIN) && (imm <= IMM13_MAX) && !imm[0];
            end
            default: begin
                inst  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction fields into a 2-entry address-tagged output FIFO
module instr_encoder
    import rv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    instr_encoder_if.slave bus
);

    logic [31:0]       word;
    logic              legal;
    logic [1:0]        count;
    logic [31:0]       head_q;
    logic [31:0]       tail_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;
    logic              accept;
    logic              push;
    logic              pop;

    imm_pack u_imm_pack (
        .fmt    (bus.fmt_i),
        .opcode (bus.opcode_i),
        .rd     (bus.rd_i),
        .rs1    (bus.rs1_i),
        .rs2    (bus.rs2_i),
        .funct3 (bus.funct3_i),
        .funct7 (bus.funct7_i),
        .imm    (bus.imm_i),
        .inst   (word),
        .legal  (legal)
    );

    assign accept = bus.in_valid_i && (count != 2'd2);
    assign push   = accept && legal;
    assign pop    = (count != 2'd0) && bus.out_ready_i;

    // Head is a dedicated register so the output holds its last word once the FIFO drains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count     <= 2'd0;
            head_q    <= 32'd0;
            tail_q    <= 32'd0;
            addr_q    <= ADDR_BASE;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q <= accept && !legal;
            if (accept && !legal && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (pop) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
            if (push && ((count == 2'd0) || pop)) begin
                head_q <= word;
            end else if (pop && (count == 2'd2)) begin
                head_q <= tail_q;
            end
            if (push && (count == 2'd1) && !pop) begin
                tail_q <= word;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.in_ready_o  = (count != 2'd2);
    assign bus.out_valid_o = (count != 2'd0);
    assign bus.inst_o      = head_q;
    assign bus.addr_o      = addr_q;
    assign bus.err_o       = err_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule
